// File: rtl/mmio_arbiter_if.sv
// Bus bundle between the two MMIO masters, the arbiter and the address decoder.
// The arbiter takes the slave view; whoever drives the requests takes the master view.
interface mmio_arbiter_if;
   logic        m0_req;
   logic        m0_we;
   logic [31:0] m0_a;
   logic [31:0] m0_wd;
   logic        m0_gnt;
   logic        m0_done;
   logic        m0_err;
   logic [31:0] m0_rd;

   logic        m1_req;
   logic        m1_we;
   logic [31:0] m1_a;
   logic [31:0] m1_wd;
   logic        m1_gnt;
   logic        m1_done;
   logic        m1_err;
   logic [31:0] m1_rd;

   logic [31:0] bus_a;
   logic [31:0] bus_wd;
   logic        bus_we;
   logic [31:0] bus_rd;
   logic        busy;

   modport slave (
      input  m0_req, m0_we, m0_a, m0_wd,
      output m0_gnt, m0_done, m0_err, m0_rd,
      input  m1_req, m1_we, m1_a, m1_wd,
      output m1_gnt, m1_done, m1_err, m1_rd,
      output bus_a, bus_wd, bus_we,
      input  bus_rd,
      output busy
   );

   modport master (
      output m0_req, m0_we, m0_a, m0_wd,
      input  m0_gnt, m0_done, m0_err, m0_rd,
      output m1_req, m1_we, m1_a, m1_wd,
      input  m1_gnt, m1_done, m1_err, m1_rd,
      input  bus_a, bus_wd, bus_we,
      output bus_rd,
      input  busy
   );
endinterface

// File: rtl/mmio_arbiter.sv
// Round-robin arbiter for two MMIO masters: one single-word access at a time,
// with per-region wait states and an error completion for unmapped addresses.
module mmio_arbiter #(
   parameter int WAIT_MEM    = 0,
   parameter int WAIT_PERIPH = 2
) (
   input logic           clk,
   input logic           rst,
   mmio_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
   typedef enum logic [1:0] {REG_MEM = 2'd0, REG_PERIPH = 2'd1, REG_ERR = 2'd2} region_t;

   localparam logic [3:0] waitMem    = 4'(WAIT_MEM);
   localparam logic [3:0] waitPeriph = 4'(WAIT_PERIPH);

   state_t      state;
   state_t      nextState;
   logic        owner;
   logic        lastServed;
   logic        weQ;
   logic        errQ;
   logic [31:0] addrQ;
   logic [31:0] wdQ;
   logic [31:0] rd0Q;
   logic [31:0] rd1Q;
   logic [3:0]  count;

   logic        anyReq;
   logic        winner;
   logic [31:0] winAddr;
   region_t     winRegion;
   logic [3:0]  winWait;
   logic        lastBusy;

   function automatic region_t classify(input logic [31:0] a);
      region_t r;
      r = REG_ERR;
      if (a[31:8] == 24'd0)
         r = REG_MEM;
      else if (a[31:12] == 20'd0 && a[11:8] inside {4'h8, 4'h9, 4'hA} && a[7:4] == 4'h0)
         r = REG_PERIPH;
      return r;
   endfunction

   // On a tie the master that was not served last wins.
   always_comb begin
      anyReq = bus.m0_req | bus.m1_req;
      if (bus.m0_req && bus.m1_req)
         winner = ~lastServed;
      else
         winner = bus.m1_req;
      winAddr   = winner ? bus.m1_a : bus.m0_a;
      winRegion = classify(winAddr);
      case (winRegion)
         REG_MEM:    winWait = waitMem;
         REG_PERIPH: winWait = waitPeriph;
         default:    winWait = 4'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= nextState;
   end

   always_comb begin
      nextState   = state;
      lastBusy    = (state == BUSY) && (count == 4'd0);
      bus.m0_gnt  = 1'b0;
      bus.m1_gnt  = 1'b0;
      bus.m0_done = 1'b0;
      bus.m1_done = 1'b0;
      bus.m0_err  = 1'b0;
      bus.m1_err  = 1'b0;
      bus.bus_a   = 32'd0;
      bus.bus_wd  = 32'd0;
      bus.bus_we  = 1'b0;
      bus.busy    = (state != IDLE);
      bus.m0_rd   = rd0Q;
      bus.m1_rd   = rd1Q;
      case (state)
         IDLE: begin
            if (anyReq)
               nextState = BUSY;
         end
         BUSY: begin
            bus.m0_gnt = ~owner;
            bus.m1_gnt = owner;
            bus.bus_a  = addrQ;
            bus.bus_wd = wdQ;
            // Write strobe only on the final wait cycle; gated by rst so an aborted access never writes.
            bus.bus_we = lastBusy && weQ && !errQ && !rst;
            if (lastBusy)
               nextState = DONE;
         end
         DONE: begin
            bus.m0_done = ~owner;
            bus.m1_done = owner;
            bus.m0_err  = ~owner & errQ;
            bus.m1_err  = owner & errQ;
            nextState   = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         owner      <= 1'b0;
         lastServed <= 1'b1;
         weQ        <= 1'b0;
         errQ       <= 1'b0;
         addrQ      <= 32'd0;
         wdQ        <= 32'd0;
         rd0Q       <= 32'd0;
         rd1Q       <= 32'd0;
         count      <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (anyReq) begin
                  owner <= winner;
                  weQ   <= winner ? bus.m1_we : bus.m0_we;
                  addrQ <= winAddr;
                  wdQ   <= winner ? bus.m1_wd : bus.m0_wd;
                  errQ  <= (winRegion == REG_ERR);
                  count <= winWait;
               end
            end
            BUSY: begin
               if (count == 4'd0) begin
                  if (!weQ) begin
                     if (owner)
                        rd1Q <= errQ ? 32'd0 : bus.bus_rd;
                     else
                        rd0Q <= errQ ? 32'd0 : bus.bus_rd;
                  end
               end else begin
                  count <= count - 4'd1;
               end
            end
            DONE: lastServed <= owner;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_arbiter.sv
// Testbench for mmio_arbiter: directed scenarios plus randomized traffic checked
// every cycle against a transaction-level schedule model.
module tb_mmio_arbiter;

   localparam int WM = 0;
   localparam int WP = 2;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   mmio_arbiter_if ifc ();

   mmio_arbiter #(.WAIT_MEM(WM), .WAIT_PERIPH(WP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   typedef struct packed {
      logic        g0, g1, d0, d1, e0, e1, busy, we, cap, own, isWrite, isErr;
      logic [31:0] a;
      logic [31:0] wd;
   } exp_t;

   exp_t        expQ[$];
   logic [31:0] mRd0;
   logic [31:0] mRd1;
   logic        mLast;

   int checks   = 0;
   int failures = 0;

   logic        sRst;
   logic        sReq0, sWe0, sReq1, sWe1;
   logic [31:0] sA0, sWd0, sA1, sWd1, sBrd;

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
      end
   endtask

   function automatic int regionOf(input logic [31:0] a);
      if (a[31:8] == 24'd0) return 0;
      if (a[31:12] == 20'd0 && (a[11:8] == 4'h8 || a[11:8] == 4'h9 || a[11:8] == 4'hA)
          && a[7:4] == 4'h0) return 1;
      return 2;
   endfunction

   // Expand one granted access into its full cycle-by-cycle output schedule.
   task automatic schedule();
      exp_t        e;
      logic        w;
      logic [31:0] a, wd;
      logic        we;
      int          rg, nWait;
      w     = (ifc.m0_req && ifc.m1_req) ? ~mLast : ifc.m1_req;
      a     = w ? ifc.m1_a  : ifc.m0_a;
      wd    = w ? ifc.m1_wd : ifc.m0_wd;
      we    = w ? ifc.m1_we : ifc.m0_we;
      rg    = regionOf(a);
      nWait = (rg == 0) ? WM : (rg == 1) ? WP : 0;
      for (int i = 0; i <= nWait; i++) begin
         e         = '0;
         e.g0      = ~w;
         e.g1      = w;
         e.busy    = 1'b1;
         e.a       = a;
         e.wd      = wd;
         e.cap     = (i == nWait);
         e.we      = (i == nWait) && we && (rg != 2);
         e.own     = w;
         e.isWrite = we;
         e.isErr   = (rg == 2);
         expQ.push_back(e);
      end
      e      = '0;
      e.d0   = ~w;
      e.d1   = w;
      e.e0   = ~w && (rg == 2);
      e.e1   = w && (rg == 2);
      e.busy = 1'b1;
      expQ.push_back(e);
      mLast = w;
   endtask

   task automatic modelUpdate();
      exp_t e;
      if (ifc.m0_req === 1'bx) return;
      if (rst) begin
         expQ.delete();
         mRd0  = 32'd0;
         mRd1  = 32'd0;
         mLast = 1'b1;
      end else if (expQ.size() == 0) begin
         if (ifc.m0_req || ifc.m1_req) schedule();
      end else begin
         e = expQ.pop_front();
         if (e.cap && !e.isWrite) begin
            if (e.own) mRd1 = e.isErr ? 32'd0 : ifc.bus_rd;
            else       mRd0 = e.isErr ? 32'd0 : ifc.bus_rd;
         end
      end
   endtask

   task automatic checkOutput();
      exp_t e;
      e = (expQ.size() == 0) ? exp_t'('0) : expQ[0];
      checkVal("m0_gnt",  ifc.m0_gnt,  e.g0);
      checkVal("m1_gnt",  ifc.m1_gnt,  e.g1);
      checkVal("m0_done", ifc.m0_done, e.d0);
      checkVal("m1_done", ifc.m1_done, e.d1);
      checkVal("m0_err",  ifc.m0_err,  e.e0);
      checkVal("m1_err",  ifc.m1_err,  e.e1);
      checkVal("busy",    ifc.busy,    e.busy);
      checkVal("bus_a",   ifc.bus_a,   e.a);
      checkVal("bus_wd",  ifc.bus_wd,  e.wd);
      checkVal("bus_we",  ifc.bus_we,  e.we);
      checkVal("m0_rd",   ifc.m0_rd,   mRd0);
      checkVal("m1_rd",   ifc.m1_rd,   mRd1);
   endtask

   task automatic applyStimulus();
      rst        = sRst;
      ifc.m0_req = sReq0;
      ifc.m0_we  = sWe0;
      ifc.m0_a   = sA0;
      ifc.m0_wd  = sWd0;
      ifc.m1_req = sReq1;
      ifc.m1_we  = sWe1;
      ifc.m1_a   = sA1;
      ifc.m1_wd  = sWd1;
      ifc.bus_rd = sBrd;
   endtask

   task automatic step();
      @(negedge clk);
      checkOutput();
      applyStimulus();
      modelUpdate();
   endtask

   function automatic logic [31:0] pickAddr();
      case ($urandom_range(0, 5))
         0:       return {24'h0, 8'($urandom)};
         1:       return {20'h0, 4'(4'h8 + 4'($urandom_range(0, 2))), 4'h0, 4'($urandom)};
         2:       return 32'h0000_0B00;
         3:       return {20'h0, 4'h8, 4'hF, 4'($urandom)};
         4:       return $urandom;
         default: return {20'h0, 4'($urandom_range(1, 7)), 8'($urandom)};
      endcase
   endfunction

   initial begin
      sRst = 1'b1;
      sReq0 = 1'b0; sWe0 = 1'b0; sA0 = '0; sWd0 = '0;
      sReq1 = 1'b0; sWe1 = 1'b0; sA1 = '0; sWd1 = '0;
      sBrd = '0;
      applyStimulus();
      expQ.delete();
      mRd0 = '0; mRd1 = '0; mLast = 1'b1;

      // Reset, then a single zero-wait memory read from master 0.
      step();
      sRst = 1'b0;
      step();
      sReq0 = 1'b1; sWe0 = 1'b0; sA0 = 32'h10; sBrd = 32'hDEADBEEF;
      step();
      sReq0 = 1'b0;
      step();
      checkVal("t1 m0_gnt", ifc.m0_gnt, 1);
      step();
      checkVal("t1 m0_done", ifc.m0_done, 1);
      checkVal("t1 m0_err", ifc.m0_err, 0);
      checkVal("t1 m0_rd", ifc.m0_rd, 32'hDEADBEEF);
      step();
      checkVal("t1 idle gnt", ifc.m0_gnt, 0);

      // Master 1 peripheral write with two wait states.
      sReq1 = 1'b1; sWe1 = 1'b1; sA1 = 32'h904; sWd1 = 32'h5;
      step();
      sReq1 = 1'b0;
      step();
      checkVal("t2 c1 gnt", ifc.m1_gnt, 1);
      checkVal("t2 c1 we", ifc.bus_we, 0);
      step();
      checkVal("t2 c2 gnt", ifc.m1_gnt, 1);
      checkVal("t2 c2 we", ifc.bus_we, 0);
      step();
      checkVal("t2 c3 gnt", ifc.m1_gnt, 1);
      checkVal("t2 c3 we", ifc.bus_we, 1);
      checkVal("t2 c3 bus_a", ifc.bus_a, 32'h904);
      checkVal("t2 c3 bus_wd", ifc.bus_wd, 32'h5);
      step();
      checkVal("t2 m1_done", ifc.m1_done, 1);
      checkVal("t2 done gnt", ifc.m1_gnt, 0);

      // Master 0 write to an unmapped address.
      sReq0 = 1'b1; sWe0 = 1'b1; sA0 = 32'hB00; sWd0 = 32'hAA;
      step();
      sReq0 = 1'b0;
      step();
      checkVal("t4 gnt", ifc.m0_gnt, 1);
      checkVal("t4 we", ifc.bus_we, 0);
      step();
      checkVal("t4 done", ifc.m0_done, 1);
      checkVal("t4 err", ifc.m0_err, 1);
      checkVal("t4 rd kept", ifc.m0_rd, 32'hDEADBEEF);
      step();

      // Both masters requesting continuously from reset.
      sRst = 1'b1;
      step();
      sRst = 1'b0; sReq0 = 1'b1; sReq1 = 1'b1; sWe0 = 1'b0; sWe1 = 1'b0;
      sA0 = 32'h20; sA1 = 32'h24; sBrd = 32'h33;
      step();
      for (int i = 1; i <= 12; i++) begin
         step();
         checkVal($sformatf("t3 gnt0 c%0d", i), ifc.m0_gnt, (i == 1 || i == 7));
         checkVal($sformatf("t3 gnt1 c%0d", i), ifc.m1_gnt, (i == 4 || i == 10));
      end
      sReq0 = 1'b0; sReq1 = 1'b0;
      for (int i = 0; i < 4; i++) step();

      // Reset during the second busy cycle of a peripheral write.
      sReq1 = 1'b1; sWe1 = 1'b1; sA1 = 32'h900; sWd1 = 32'h77;
      step();
      sReq1 = 1'b0;
      step();
      sRst = 1'b1;
      step();
      #1;
      checkVal("t5 rst-cycle we", ifc.bus_we, 0);
      sRst = 1'b0;
      step();
      checkVal("t5 gnt", ifc.m1_gnt, 0);
      checkVal("t5 busy", ifc.busy, 0);
      checkVal("t5 bus_a", ifc.bus_a, 0);
      checkVal("t5 m0_rd", ifc.m0_rd, 0);
      step();
      checkVal("t5 no done", ifc.m1_done, 0);
      step();
      checkVal("t5 no we", ifc.bus_we, 0);

      // Independent read-data registers per master.
      sReq0 = 1'b1; sWe0 = 1'b0; sA0 = 32'h800; sBrd = 32'h11;
      step();
      sReq0 = 1'b0;
      for (int i = 0; i < 4; i++) step();
      sReq1 = 1'b1; sWe1 = 1'b0; sA1 = 32'h800; sBrd = 32'h22;
      step();
      sReq1 = 1'b0;
      for (int i = 0; i < 4; i++) step();
      checkVal("t6 m0_rd", ifc.m0_rd, 32'h11);
      checkVal("t6 m1_rd", ifc.m1_rd, 32'h22);

      // Randomized traffic with occasional resets.
      for (int n = 0; n < 3000; n++) begin
         sRst  = ($urandom_range(0, 149) == 0);
         sReq0 = ($urandom_range(0, 2) != 0);
         sReq1 = ($urandom_range(0, 2) != 0);
         sWe0  = 1'($urandom);
         sWe1  = 1'($urandom);
         sA0   = pickAddr();
         sA1   = pickAddr();
         sWd0  = $urandom;
         sWd1  = $urandom;
         sBrd  = $urandom;
         step();
      end
      sRst = 1'b0; sReq0 = 1'b0; sReq1 = 1'b0;
      for (int i = 0; i < 20; i++) step();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/mmio_arbiter.md
# mmio_arbiter

Two-master arbiter and sequencer for the memory-mapped I/O bus of the processor. Master 0 (CPU load/store port) and master 1 (DMA/debug port) request single-word accesses. The block grants one master at a time using round-robin priority, drives the shared address/write-data/write-enable lines into the address decoder, and inserts programmable wait states per region. It returns read data, completion and error status to the granted master.

## Interface
- WAIT_MEM, 0, extra wait cycles for data-memory accesses (0..15)
- WAIT_PERIPH, 2, extra wait cycles for peripheral accesses (0..15)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- m0_req  in  1  master 0 access request (level)
- m0_we  in  1  master 0 write (1) / read (0)
- m0_a  in  32  master 0 byte address
- m0_wd  in  32  master 0 write data
- m0_gnt  out  1  master 0 owns bus (BUSY state)
- m0_done  out  1  one-cycle completion pulse for master 0
- m0_err  out  1  one-cycle pulse with m0_done on unmapped address
- m0_rd  out  32  master 0 read data, registered
- m1_req, m1_we, m1_a, m1_wd, m1_gnt, m1_done, m1_err, m1_rd: same as master 0
- bus_a  out  32  address to decoder
- bus_wd  out  32  write data to decoder/peripherals
- bus_we  out  1  write enable to decoder
- bus_rd  in  32  read data from decoder-selected source
- busy  out  1  high in any state except IDLE

## Operation
- Region classification of the latched address:
  - MEM: a[31:8]==0.
  - PERIPH: a[31:12]==0, a[11:8] in {8,9,A}, a[7:4]==0.
  - Otherwise ERR.
- States: IDLE, BUSY, DONE. Transitions IDLE->BUSY->DONE->IDLE.
- IDLE:
  - Samples m0_req/m1_req.
  - If exactly one is high, that master wins.
  - If both are high, the master not served last wins.
  - On the winning cycle, latch owner, we, a, wd.
  - Load counter with WAIT_MEM, WAIT_PERIPH, or 0 for ERR. Go BUSY.
- BUSY:
  - ownerâs gnt=1; bus_a/bus_wd driven from latches.
  - Counter decrements each cycle.
  - When counter==0 (last BUSY cycle):
    - bus_we = latched we, forced 0 for ERR.
    - bus_rd captured into ownerâs rd register on reads; rd register loaded 0 for ERR reads.
    - Go DONE.
  - bus_we is 0 on all other BUSY cycles.
- DONE:
  - ownerâs done=1; err=1 if ERR.
  - Last-served pointer updated to owner. Go IDLE.
- req is ignored outside IDLE. A master still holding req in DONE is re-arbitrated in the following IDLE cycle.
- Writes leave the rd register unchanged. Each rd register holds its value until that masterâs next completed read.
- Outside BUSY, bus_a and bus_wd are 0 and bus_we is 0.
- Counter is 4 bits; parameters above 15 are illegal.

## Timing
- Reset values:
  - state=IDLE.
  - All gnt, done, err, bus_we, busy = 0.
  - bus_a, bus_wd, m0_rd, m1_rd = 0.
  - Last-served pointer = master 1, so master 0 wins the first tie.
- Latency:
  - req sampled in IDLE at cycle t.
  - BUSY occupies cycles t+1 .. t+1+W, where W is the regionâs wait count (0 for ERR).
  - done pulses at t+2+W; rd is valid from that cycle.
  - IDLE at t+3+W.
- Throughput: one access per W+3 cycles. There is no back-to-back BUSY.
- Reset asserted in any state:
  - Next cycle is IDLE with reset values.
  - The in-flight access is aborted with no done.
  - No bus_we is issued in the reset cycle or after.
- Simultaneous request with the other master's done: the DONE cycle completes first. Arbitration occurs in the next IDLE cycle with the updated pointer.
- Exactly one of m0_gnt/m1_gnt is high in BUSY. Both are low otherwise.

## Test plan
- Reset, then m0 read at a=0x0000_0010, bus_rd=0xDEADBEEF, WAIT_MEM=0:
  - m0_gnt for 1 cycle.
  - m0_done 2 cycles after the req sample.
  - m0_rd=0xDEADBEEF, m0_err=0.
- m1 write a=0x0000_0904, wd=0x5, WAIT_PERIPH=2:
  - m1_gnt for 3 cycles.
  - bus_we high only on the 3rd cycle, with bus_a=0x904, bus_wd=0x5.
  - m1_done at cycle t+4.
- Both req high continuously from reset:
  - Grants alternate m0, m1, m0, m1.
  - Each grant is followed by done before the next grant.
- m0 write to a=0x0000_0B00:
  - bus_we stays 0 throughout.
  - m0_done and m0_err pulse together at t+2.
  - m0_rd unchanged.
- rst asserted in 2nd BUSY cycle of a peripheral write:
  - Next cycle all outputs are at reset values.
  - No bus_we and no done observed.
- m0 read of 0x800 (rd=0x11), then m1 read (rd=0x22):
  - m0_rd stays 0x11 while m1_rd becomes 0x22.
